// File: rtl/kbd_event_fifo_if.sv
// Keyboard event push port and CPU register-window port of the event FIFO.
interface kbd_event_fifo_if #(
  parameter int unsigned AW = 3
);
  logic          kbd_data_ready;
  logic [7:0]    kbd_scan_code;
  logic [7:0]    kbd_ascii;
  logic          kbd_extended;
  logic          kbd_released;
  logic          kbd_shift_key_on;
  logic          rd_req;
  logic [1:0]    reg_sel;
  logic [7:0]    dout;
  logic          kbd_irq;
  logic [AW:0]   count;

  // Decoder/CPU side drives events and reads; the FIFO answers.
  modport master (
    output kbd_data_ready, kbd_scan_code, kbd_ascii,
    output kbd_extended, kbd_released, kbd_shift_key_on,
    output rd_req, reg_sel,
    input  dout, kbd_irq, count
  );

  modport slave (
    input  kbd_data_ready, kbd_scan_code, kbd_ascii,
    input  kbd_extended, kbd_released, kbd_shift_key_on,
    input  rd_req, reg_sel,
    output dout, kbd_irq, count
  );
endinterface

// File: rtl/kbd_event_fifo.sv
// PS/2 keyboard event FIFO with a CPU register window; the head entry is
// popped when a STATUS read is released (synchronised read-then-release).
module kbd_event_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic           clk_50,
  input  logic           reset,
  kbd_event_fifo_if.slave bus
);

  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  typedef struct packed {
    logic       shift;
    logic       extended;
    logic       released;
    logic [7:0] scan;
    logic [7:0] ascii;
  } kbd_evt_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } state_t;

  kbd_evt_t      mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          irq_q;
  logic          rd_s1_q, rd_s2_q, rd_s3_q;
  state_t        state_q, state_d;

  logic          rise_c, fall_c, nonempty_c, full_c;
  logic          push_c, pop_c;
  kbd_evt_t      head_c, entry_c;
  logic [7:0]    dout_c;

  assign rise_c     = rd_s2_q & ~rd_s3_q;
  assign fall_c     = ~rd_s2_q & rd_s3_q;
  assign nonempty_c = (count_q != '0);
  assign full_c     = (count_q == DEPTH_C);
  assign head_c     = mem_q[rd_ptr_q];

  assign entry_c = '{shift:    bus.kbd_shift_key_on,
                     extended: bus.kbd_extended,
                     released: bus.kbd_released,
                     scan:     bus.kbd_scan_code,
                     ascii:    bus.kbd_ascii};

  // Pop FSM: arm on a STATUS read of a non-empty FIFO, pop on its release.
  always_comb begin
    state_d = state_q;
    pop_c   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rise_c && (bus.reg_sel == 2'd2) && nonempty_c) begin
          state_d = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (fall_c) begin
          state_d = ST_IDLE;
          pop_c   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pointer, occupancy and sticky overflow next-state.
  always_comb begin
    push_c     = bus.kbd_data_ready & (~full_c | pop_c);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push_c) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
    if (pop_c) begin
      overflow_d = 1'b0;
    end else if (bus.kbd_data_ready && full_c) begin
      overflow_d = 1'b1;
    end
  end

  // Control state, read synchroniser and interrupt register.
  always_ff @(posedge clk_50 or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      irq_q      <= 1'b0;
      rd_s1_q    <= 1'b0;
      rd_s2_q    <= 1'b0;
      rd_s3_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      irq_q      <= (count_d != '0);
      rd_s1_q    <= bus.rd_req;
      rd_s2_q    <= rd_s1_q;
      rd_s3_q    <= rd_s2_q;
    end
  end

  // Event storage; contents are only observed when the FIFO is non-empty.
  always_ff @(posedge clk_50) begin
    if (push_c) begin
      mem_q[wr_ptr_q] <= entry_c;
    end
  end

  // Register window; head fields read as zero when empty.
  always_comb begin
    dout_c = 8'h00;
    case (bus.reg_sel)
      2'd0: dout_c = nonempty_c ? head_c.ascii : 8'h00;
      2'd1: dout_c = nonempty_c ? head_c.scan  : 8'h00;
      2'd2: dout_c = {nonempty_c, overflow_q, 3'b000,
                      nonempty_c & head_c.shift,
                      nonempty_c & head_c.extended,
                      nonempty_c & head_c.released};
      default: dout_c = 8'(count_q);
    endcase
  end

  assign bus.dout    = dout_c;
  assign bus.count   = count_q;
  assign bus.kbd_irq = irq_q;

endmodule

// File: tb/tb_kbd_event_fifo.sv
// Directed bench for kbd_event_fifo: push/pop ordering, overflow,
// push coincident with pop, empty STATUS reads and reset while armed.
module tb_kbd_event_fifo;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 3;

  logic clk_50;
  logic reset;
  int   errors;
  int   checks;

  kbd_event_fifo_if #(.AW(AW)) bus ();

  kbd_event_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk_50 (clk_50),
    .reset  (reset),
    .bus    (bus.slave)
  );

  initial clk_50 = 1'b0;
  always #5 clk_50 = ~clk_50;

  task automatic push_one(input logic [7:0] a, input logic [7:0] s, input logic [2:0] f);
    @(posedge clk_50); #1;
    bus.kbd_data_ready = 1'b1;
    bus.kbd_ascii      = a;
    bus.kbd_scan_code  = s;
    {bus.kbd_shift_key_on, bus.kbd_extended, bus.kbd_released} = f;
  endtask

  task automatic push_end();
    @(posedge clk_50); #1;
    bus.kbd_data_ready = 1'b0;
  endtask

  task automatic peek(input logic [1:0] sel, output logic [7:0] d);
    bus.reg_sel = sel;
    #1;
    d = bus.dout;
  endtask

  task automatic cpu_read(input logic [1:0] sel, output logic [7:0] d);
    @(posedge clk_50); #1;
    bus.reg_sel = sel;
    bus.rd_req  = 1'b1;
    repeat (5) @(posedge clk_50);
    #1;
    d = bus.dout;
    bus.rd_req = 1'b0;
    repeat (6) @(posedge clk_50);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    reset = 1'b0;
    #23;
    for (int s = 0; s < 4; s++) begin
      peek(2'(s), d);
      checks++;
      if (d !== 8'h00) begin
        errors++; $display("FAIL reset_dout sel=%0d got=%h exp=00", s, d);
      end
    end
    checks++;
    if (bus.kbd_irq !== 1'b0) begin
      errors++; $display("FAIL reset_irq got=%b exp=0", bus.kbd_irq);
    end
    checks++;
    if (bus.count !== 4'd0) begin
      errors++; $display("FAIL reset_count got=%0d exp=0", bus.count);
    end
    @(posedge clk_50); #1;
    reset = 1'b1;
  endtask

  task automatic test_single();
    logic [7:0] d;
    push_one(8'h61, 8'h1C, 3'b000);
    push_end();
    checks++;
    if (bus.count !== 4'd1 || bus.kbd_irq !== 1'b1) begin
      errors++; $display("FAIL single_count got=%0d/%b exp=1/1", bus.count, bus.kbd_irq);
    end
    peek(2'd0, d);
    checks++;
    if (d !== 8'h61) begin errors++; $display("FAIL single_ascii got=%h exp=61", d); end
    peek(2'd1, d);
    checks++;
    if (d !== 8'h1C) begin errors++; $display("FAIL single_scan got=%h exp=1c", d); end
    @(posedge clk_50); #1;
    bus.reg_sel = 2'd2;
    bus.rd_req  = 1'b1;
    repeat (5) @(posedge clk_50);
    #1;
    checks++;
    if (bus.dout !== 8'h80) begin errors++; $display("FAIL single_status got=%h exp=80", bus.dout); end
    bus.rd_req = 1'b0;
    repeat (4) @(posedge clk_50);
    #1;
    checks++;
    if (bus.count !== 4'd0 || bus.kbd_irq !== 1'b0) begin
      errors++; $display("FAIL single_pop got=%0d/%b exp=0/0", bus.count, bus.kbd_irq);
    end
  endtask

  task automatic test_order();
    logic [7:0] d;
    logic [7:0] exp_st;
    push_one(8'h31, 8'h16, 3'b000);
    push_one(8'h32, 8'h1E, 3'b000);
    push_one(8'h33, 8'h26, 3'b101);
    push_end();
    for (int i = 0; i < 3; i++) begin
      cpu_read(2'd0, d);
      checks++;
      if (d !== 8'(8'h31 + i)) begin
        errors++; $display("FAIL order_ascii i=%0d got=%h exp=%h", i, d, 8'(8'h31 + i));
      end
      checks++;
      if (bus.count !== 4'(3 - i)) begin
        errors++; $display("FAIL order_nopop i=%0d got=%0d exp=%0d", i, bus.count, 3 - i);
      end
      exp_st = (i == 2) ? 8'h85 : 8'h80;
      cpu_read(2'd2, d);
      checks++;
      if (d !== exp_st) begin
        errors++; $display("FAIL order_status i=%0d got=%h exp=%h", i, d, exp_st);
      end
      checks++;
      if (bus.count !== 4'(2 - i)) begin
        errors++; $display("FAIL order_pop i=%0d got=%0d exp=%0d", i, bus.count, 2 - i);
      end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] d;
    for (int i = 0; i <= int'(DEPTH); i++) begin
      push_one(8'(8'h40 + i), 8'(8'h10 + i), 3'b000);
    end
    push_end();
    checks++;
    if (bus.count !== 4'(DEPTH)) begin
      errors++; $display("FAIL ovf_count got=%0d exp=%0d", bus.count, DEPTH);
    end
    peek(2'd2, d);
    checks++;
    if (d !== 8'hC0) begin errors++; $display("FAIL ovf_status got=%h exp=c0", d); end
    cpu_read(2'd2, d);
    peek(2'd2, d);
    checks++;
    if (d !== 8'h80) begin errors++; $display("FAIL ovf_clear got=%h exp=80", d); end
    peek(2'd0, d);
    checks++;
    if (d !== 8'h41) begin errors++; $display("FAIL ovf_head got=%h exp=41", d); end
    peek(2'd3, d);
    checks++;
    if (d !== 8'h07) begin errors++; $display("FAIL ovf_countreg got=%h exp=07", d); end
    repeat (7) cpu_read(2'd2, d);
    checks++;
    if (bus.count !== 4'd0 || bus.kbd_irq !== 1'b0) begin
      errors++; $display("FAIL ovf_drain got=%0d/%b exp=0/0", bus.count, bus.kbd_irq);
    end
  endtask

  task automatic test_push_on_pop();
    logic [7:0] d;
    for (int i = 0; i < int'(DEPTH); i++) begin
      push_one(8'(8'h50 + i), 8'(8'h20 + i), 3'b000);
    end
    push_end();
    @(posedge clk_50); #1;
    bus.reg_sel = 2'd2;
    bus.rd_req  = 1'b1;
    repeat (5) @(posedge clk_50);
    #1;
    checks++;
    if (bus.dout !== 8'h80) begin errors++; $display("FAIL pop_push_pre got=%h exp=80", bus.dout); end
    bus.rd_req = 1'b0;
    // Release seen by rd_s2 two edges later; pop happens on the third edge.
    @(posedge clk_50);
    @(posedge clk_50); #1;
    push_one_inline(8'h58, 8'h28);
    @(posedge clk_50); #1;
    bus.kbd_data_ready = 1'b0;
    checks++;
    if (bus.count !== 4'(DEPTH)) begin
      errors++; $display("FAIL pop_push_count got=%0d exp=%0d", bus.count, DEPTH);
    end
    peek(2'd2, d);
    checks++;
    if (d !== 8'h80) begin errors++; $display("FAIL pop_push_ovf got=%h exp=80", d); end
    for (int i = 0; i < int'(DEPTH); i++) begin
      peek(2'd0, d);
      checks++;
      if (d !== 8'(8'h51 + i)) begin
        errors++; $display("FAIL pop_push_drain i=%0d got=%h exp=%h", i, d, 8'(8'h51 + i));
      end
      cpu_read(2'd2, d);
    end
    checks++;
    if (bus.count !== 4'd0) begin errors++; $display("FAIL pop_push_empty got=%0d exp=0", bus.count); end
  endtask

  task automatic push_one_inline(input logic [7:0] a, input logic [7:0] s);
    bus.kbd_data_ready = 1'b1;
    bus.kbd_ascii      = a;
    bus.kbd_scan_code  = s;
    {bus.kbd_shift_key_on, bus.kbd_extended, bus.kbd_released} = 3'b000;
  endtask

  task automatic test_empty_and_reset();
    logic [7:0] d;
    cpu_read(2'd2, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL empty_status got=%h exp=00", d); end
    checks++;
    if (bus.count !== 4'd0 || bus.kbd_irq !== 1'b0) begin
      errors++; $display("FAIL empty_nopop got=%0d/%b exp=0/0", bus.count, bus.kbd_irq);
    end
    push_one(8'h71, 8'h15, 3'b000);
    push_end();
    checks++;
    if (bus.count !== 4'd1) begin errors++; $display("FAIL empty_push got=%0d exp=1", bus.count); end
    @(posedge clk_50); #1;
    bus.reg_sel = 2'd2;
    bus.rd_req  = 1'b1;
    repeat (4) @(posedge clk_50);
    #1;
    reset = 1'b0;
    #2;
    checks++;
    if (bus.count !== 4'd0 || bus.kbd_irq !== 1'b0 || bus.dout !== 8'h00) begin
      errors++;
      $display("FAIL armed_reset got=%0d/%b/%h exp=0/0/00", bus.count, bus.kbd_irq, bus.dout);
    end
    @(posedge clk_50); #1;
    reset = 1'b1;
    repeat (4) @(posedge clk_50);
    push_one(8'h72, 8'h1D, 3'b000);
    push_end();
    bus.rd_req = 1'b0;
    repeat (6) @(posedge clk_50);
    #1;
    checks++;
    if (bus.count !== 4'd1 || bus.kbd_irq !== 1'b1) begin
      errors++; $display("FAIL armed_nopop got=%0d/%b exp=1/1", bus.count, bus.kbd_irq);
    end
    peek(2'd0, d);
    checks++;
    if (d !== 8'h72) begin errors++; $display("FAIL armed_head got=%h exp=72", d); end
    cpu_read(2'd2, d);
    checks++;
    if (bus.count !== 4'd0) begin errors++; $display("FAIL armed_final got=%0d exp=0", bus.count); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b1;
    bus.kbd_data_ready   = 1'b0;
    bus.kbd_scan_code    = 8'h00;
    bus.kbd_ascii        = 8'h00;
    bus.kbd_extended     = 1'b0;
    bus.kbd_released     = 1'b0;
    bus.kbd_shift_key_on = 1'b0;
    bus.rd_req           = 1'b0;
    bus.reg_sel          = 2'd0;
    #2;
    test_reset();
    test_single();
    test_order();
    test_overflow();
    test_push_on_pop();
    test_empty_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
